timer_arb: RTL and testbench
============================

TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 Parameter NBITS, default 32, width of each duration and of the internal down-counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 req  input  4  level request from requester i (bit i).
REQ-005 dur  input  4*NBITS  packed durations; requester i uses slice dur[i*NBITS +: NBITS].
REQ-006 gnt  output  4  one-hot grant; at most one bit high.
REQ-007 done  output  4  one-cycle expiry pulse to the granted requester.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 count  output  NBITS  current remaining count of the shared timer.

Function
REQ-010 The block SHALL share one internal NBITS down-counter among 4 requesters using a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with any req bit high, the block SHALL select the first requester with req high, searching round-robin from (last+1) mod 4.
REQ-012 On that edge the block SHALL go to RUN, set gnt[sel], load count with dur slice sel, and set last to sel.
REQ-013 In IDLE with req all zero, the block SHALL hold: gnt=0, done=0, and count unchanged.
REQ-014 In RUN with count not equal to 0, count SHALL decrement by 1 per cycle.
REQ-015 In RUN with count equal to 0, the next state SHALL be DONE.
REQ-016 In DONE, done[sel] SHALL be high for exactly one cycle with gnt[sel] still high; the next state SHALL be IDLE with gnt=0.
REQ-017 Latency: req sampled at edge E0 gives done high in the cycle after edge E0+D+1, where D is the loaded duration.
REQ-018 D=0 SHALL be legal: the block goes RUN (count 0), then DONE, then IDLE.
REQ-019 The counter SHALL never wrap; the maximum D is 2^NBITS-1.
REQ-020 Changes to dur after load SHALL have no effect on the running count.
REQ-021 Requests arriving during RUN or DONE SHALL wait; the block returns to IDLE for at least one cycle between grants.
REQ-022 When several requests are simultaneous, the round-robin order SHALL guarantee that each pending requester is served within 4 grants.
REQ-023 done and gnt SHALL be registered outputs with no combinational path from req.

Reset
REQ-024 When reset is low at a rising edge, the next state SHALL be: state=IDLE, gnt=0, done=0, busy=0, count=0, last=3 (so req[0] has first priority).
REQ-025 A reset during RUN or DONE SHALL abandon the interval without asserting done.

Configuration
REQ-026 Macro TIMER_ARB_ABORT_EN SHALL select request-drop behaviour.
REQ-027 With TIMER_ARB_ABORT_EN defined: if req[sel] is low during RUN, the next state SHALL be IDLE with gnt=0, no done pulse, and count cleared to 0; last stays at sel.
REQ-028 With TIMER_ARB_ABORT_EN not defined: req[sel] SHALL be ignored once granted, and the interval always runs to DONE.

Verification
REQ-029 Single request, reset released, req=0001, dur0=3 -> gnt=0001 after the first edge; count runs 3,2,1,0; done=0001 for one cycle 5 edges after the request; busy low the cycle after.
REQ-030 All requests held, req=1111, all durations 1 -> grant order 0,1,2,3,0; each done pulse is one cycle long; gnt is never multi-hot.
REQ-031 Zero duration, req=0100, dur2=0 -> RUN then DONE; done=0100 on the cycle after edge E0+1.
REQ-032 Reset mid-run, dur1=10, reset low at count=6 -> gnt=0, count=0, no done pulse; the next req=0011 is granted to requester 0.
REQ-033 Abort (macro defined), req0 drops at count=2 -> IDLE next cycle, done stays 0; macro undefined -> done=0001 still occurs on schedule.
REQ-034 Maximum duration, NBITS=4, dur=15 -> count runs 15 down to 0 without wrap; done occurs after 16 RUN cycles.

Source files
------------

// File: rtl/timer_arb.sv
// rtl/timer_arb.sv - four-requester round-robin arbiter sharing one down-counter timer.
// Optional macro TIMER_ARB_ABORT_EN: a granted requester dropping req during RUN abandons its interval.
module timer_arb #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*NBITS-1:0] dur,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy,
  output logic [NBITS-1:0]   count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [3:0]       gnt_n, done_n;
  logic [NBITS-1:0] count_n;
  logic [1:0]       last, last_n;
  logic [1:0]       pick, idx;
  logic             found;
  logic [NBITS-1:0] dur_slice [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dur_slice[i] = dur[i*NBITS +: NBITS];
    end
  end

  // Round-robin search starting just after the last winner; k=4 wraps back to last itself.
  always_comb begin
    pick  = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = 4'b0000;
    count_n = count;
    last_n  = last;
    case (state)
      ST_IDLE: begin
        gnt_n = 4'b0000;
        if (found) begin
          state_n = ST_RUN;
          gnt_n   = 4'b0001 << pick;
          count_n = dur_slice[pick];
          last_n  = pick;
        end
      end
      ST_RUN: begin
`ifdef TIMER_ARB_ABORT_EN
        if (!req[last]) begin
          state_n = ST_IDLE;
          gnt_n   = 4'b0000;
          count_n = '0;
        end else
`endif
        if (count != '0) begin
          count_n = count - NBITS'(1);
        end else begin
          state_n = ST_DONE;
          done_n  = gnt;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      gnt   <= 4'b0000;
      done  <= 4'b0000;
      count <= '0;
      last  <= 2'd3;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      count <= count_n;
      last  <= last_n;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_timer_arb.sv
// tb/tb_timer_arb.sv - self-checking bench for timer_arb (NBITS=4), vectors plus a transaction-level model.
// Honours TIMER_ARB_ABORT_EN the same way as the design.
module tb_timer_arb;

  localparam int NB = 4;
`ifdef TIMER_ARB_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic [4*NB-1:0] dur;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic          busy;
  logic [NB-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner (-1 = none), cycles elapsed since the grant, loaded duration.
  int m_owner = -1;
  int m_el    = 0;
  int m_d     = 0;
  int m_last  = 3;
  int m_cnt   = 0;

  timer_arb #(.NBITS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dur   (dur),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [3:0] rq, input logic [15:0] d);
    bit hit;
    int i;
    if (!r) begin
      m_owner = -1; m_el = 0; m_d = 0; m_cnt = 0; m_last = 3;
    end else if (m_owner < 0) begin
      if (rq != 4'b0000) begin
        hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          i = (m_last + k) % 4;
          if (!hit && rq[i]) begin
            m_owner = i;
            hit = 1'b1;
          end
        end
        m_d = (int'(d) >> (NB * m_owner)) & 15;
        m_el = 0;
        m_cnt = m_d;
        m_last = m_owner;
      end
    end else if (m_el <= m_d) begin
      if (ABORT && !rq[m_owner]) begin
        m_owner = -1;
        m_cnt = 0;
      end else begin
        m_el++;
        m_cnt = (m_el <= m_d) ? (m_d - m_el) : 0;
      end
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] d);
    reset = r;
    req   = rq;
    dur   = d;
    model_update(r, rq, d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    int eg;
    int ed;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ed = (m_owner >= 0 && m_el == m_d + 1) ? (1 << m_owner) : 0;
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".done"}, done, ed);
    chk({tag, ".busy"}, busy, (m_owner >= 0) ? 1 : 0);
    chk({tag, ".count"}, count, m_cnt);
    chk({tag, ".onehot"}, ($countones(gnt) <= 1) ? 1 : 0, 1);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [15:0] d;
    logic [3:0]  e_gnt;
    logic [3:0]  e_done;
    logic        e_busy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[10];

  initial begin
    int order[$];
    int exp_order[5];
    logic [3:0] prev_gnt;
    int dlen;
    bit done_seen;

    // Reset, single request dur0=3, then zero-duration request from requester 2.
    vt[0] = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vt[1] = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd3};
    vt[2] = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd2};
    vt[3] = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd1};
    vt[4] = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0};
    vt[5] = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 1'b1, 4'd0};
    vt[6] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vt[7] = '{1'b1, 4'b0100, 16'h0000, 4'b0100, 4'b0000, 1'b1, 4'd0};
    vt[8] = '{1'b1, 4'b0100, 16'h0000, 4'b0100, 4'b0100, 1'b1, 4'd0};
    vt[9] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b0; req = 4'b0000; dur = '0;

    for (int v = 0; v < 10; v++) begin
      step(vt[v].rst, vt[v].rq, vt[v].d);
      chk($sformatf("vec%0d.gnt", v), gnt, vt[v].e_gnt);
      chk($sformatf("vec%0d.done", v), done, vt[v].e_done);
      chk($sformatf("vec%0d.busy", v), busy, vt[v].e_busy);
      chk($sformatf("vec%0d.count", v), count, vt[v].e_cnt);
    end

    // Maximum duration 15 with dur changed after load; last=2 so requester 0 wins.
    step(1'b1, 4'b0001, 16'h000F);
    chk("max.gnt", gnt, 4'b0001);
    chk("max.load", count, 15);
    for (int c = 14; c >= 0; c--) begin
      step(1'b1, 4'b0001, 16'h0005);
      chk("max.count", count, c);
      chk("max.nodone", done, 0);
    end
    step(1'b1, 4'b0001, 16'h0005);
    chk("max.done", done, 4'b0001);
    chk("max.endcount", count, 0);
    step(1'b1, 4'b0000, 16'h0000);
    chk_model("max.idle");

    // Reset in the middle of requester 1's interval.
    step(1'b0, 4'b0000, 16'h0000);
    step(1'b1, 4'b0010, 16'h00A0);
    chk("rst.gnt", gnt, 4'b0010);
    chk("rst.load", count, 10);
    for (int c = 0; c < 4; c++) step(1'b1, 4'b0010, 16'h00A0);
    chk("rst.count6", count, 6);
    step(1'b0, 4'b0010, 16'h00A0);
    chk("rst.gnt0", gnt, 0);
    chk("rst.count0", count, 0);
    chk("rst.done0", done, 0);
    chk("rst.busy0", busy, 0);
    step(1'b1, 4'b0011, 16'h0021);
    chk("rst.regrant", gnt, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b0000, 16'h0000);
      chk_model("rst.tail");
    end

    // Requester 0 drops its request at count=2.
    step(1'b0, 4'b0000, 16'h0000);
    step(1'b1, 4'b0001, 16'h0005);
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0001, 16'h0005);
    chk("abt.count2", count, 2);
    done_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b0000, 16'h0005);
      chk_model("abt");
      if (done != 0) done_seen = 1'b1;
      if (c == 0) chk("abt.busy_after_drop", busy, ABORT ? 0 : 1);
    end
    chk("abt.done_seen", done_seen, ABORT ? 0 : 1);

    // All four requesting, all durations 1.
    step(1'b0, 4'b0000, 16'h0000);
    prev_gnt = 4'b0000;
    dlen = 0;
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 4'b1111, 16'h1111);
      chk_model("rr");
      if (gnt != 0 && prev_gnt == 0)
        for (int b = 0; b < 4; b++) if (gnt[b]) order.push_back(b);
      if (done != 0) dlen++;
      else if (dlen != 0) begin
        chk("rr.donelen", dlen, 1);
        dlen = 0;
      end
      prev_gnt = gnt;
    end
    chk("rr.ngrants", (order.size() >= 5) ? 1 : 0, 1);
    for (int g = 0; g < 5 && g < order.size(); g++)
      chk($sformatf("rr.order%0d", g), order[g], exp_order[g]);

    // Randomized traffic against the model.
    step(1'b0, 4'b0000, 16'h0000);
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic [3:0] rq;
      r  = ($urandom_range(0, 99) != 0);
      rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if (ABORT && $urandom_range(0, 3) != 0) rq = 4'b1111;
      step(r, rq, 16'($urandom));
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
